// File: rtl/mul_pipe.sv
// Fully pipelined signed/unsigned multiplier with val/rdy handshakes on both sides.
// Stage 0 registers operands; the product is formed from stage 0 and shifted through the rest.
module mul_pipe #(
  parameter int unsigned p_width   = 4,
  parameter int unsigned p_nstages = 3,
  parameter int unsigned p_occ_w   = $clog2(p_nstages + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic [2*p_width-1:0]   req_msg,
  input  logic                   req_signed,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic [2*p_width-1:0]   resp_msg,
  output logic [p_occ_w-1:0]     occupancy
);

  localparam int unsigned W2 = 2 * p_width;

  logic [p_nstages-1:0] v_q;
  logic [p_nstages-1:0] en;
  logic [p_width-1:0]   a_q;
  logic [p_width-1:0]   b_q;
  logic                 sgn_q;
  logic [W2-1:0]        a_ext;
  logic [W2-1:0]        b_ext;
  logic [W2-1:0]        prod;
  logic [p_occ_w-1:0]   occ_q;
  logic                 req_go;
  logic                 resp_go;

  // A stage may advance if it is empty or its successor advances; this collapses bubbles.
  always_comb begin : adv
    logic carry;
    carry = resp_rdy;
    en    = '0;
    for (int i = int'(p_nstages) - 1; i >= 0; i--) begin
      carry = !v_q[i] | carry;
      en[i] = carry;
    end
  end

  assign req_rdy   = en[0];
  assign req_go    = req_val & req_rdy;
  assign resp_val  = v_q[p_nstages-1];
  assign resp_go   = resp_val & resp_rdy;
  assign occupancy = occ_q;

  // Low W2 bits of the extended product are exact for both signed and unsigned operands.
  always_comb begin
    a_ext = sgn_q ? {{p_width{a_q[p_width-1]}}, a_q} : {{p_width{1'b0}}, a_q};
    b_ext = sgn_q ? {{p_width{b_q[p_width-1]}}, b_q} : {{p_width{1'b0}}, b_q};
    prod  = a_ext * b_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      occ_q <= '0;
    end else begin
      if (en[0]) v_q[0] <= req_val;
      if (req_go) begin
        a_q   <= req_msg[p_width-1:0];
        b_q   <= req_msg[W2-1:p_width];
        sgn_q <= req_signed;
      end
      for (int i = 1; i < int'(p_nstages); i++) begin
        if (en[i]) v_q[i] <= v_q[i-1];
      end
      case ({req_go, resp_go})
        2'b10:   occ_q <= occ_q + p_occ_w'(1);
        2'b01:   occ_q <= occ_q - p_occ_w'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  if (p_nstages > 1) begin : g_pipe
    logic [W2-1:0] data_q [p_nstages-1];

    // data_q[j] is the product held by stage j+1.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int j = 0; j < int'(p_nstages) - 1; j++) data_q[j] <= '0;
      end else begin
        if (en[1]) data_q[0] <= prod;
        for (int j = 1; j < int'(p_nstages) - 1; j++) begin
          if (en[j+1]) data_q[j] <= data_q[j-1];
        end
      end
    end

    assign resp_msg = data_q[p_nstages-2];
  end else begin : g_comb
    assign resp_msg = prod;
  end

endmodule
